// File: rtl/ml_kem_pkg.sv
// ml_kem_pkg: ML-KEM constants, zeta table and coefficient helpers shared by poly_basemul
package ml_kem_pkg;
    typedef logic signed [15:0] coeff_t;
    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int QINV = -3327;
    localparam int MONT = 2285;
    localparam int BARRETT_V = 20159;
    localparam int ZETAS [128] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    function automatic coeff_t barrett_reduce(input coeff_t x);
        int t;
        t = ((BARRETT_V * int'(x) + (1 <<< 25)) >>> 26) * KYBER_Q;
        return coeff_t'(int'(x) - t);
    endfunction
endpackage

// File: rtl/fqmul.sv
// fqmul: one registered stage computing the Montgomery product x*y*2^-16 mod Q, valid in/out
module fqmul
    import ml_kem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   go,
    input  coeff_t x,
    input  coeff_t y,
    output logic   valid,
    output coeff_t z
);
    logic signed [31:0] prod, diff;
    coeff_t t;

    // t is chosen so that t*Q cancels the low 16 bits of the product, making the shift exact
    always_comb begin
        prod = 32'(x) * 32'(y);
        t = coeff_t'(prod * QINV);
        diff = prod - 32'(t) * KYBER_Q;
    end

    // Capture the reduced product on launch; valid tracks launch one cycle later
    always_ff @(posedge clk) begin
        if (rst) valid <= 1'b0;
        else valid <= go;
        if (go) z <= diff[31:16];
    end
endmodule

// File: rtl/poly_basemul.sv
// poly_basemul: streaming NTT-domain pointwise multiply (poly_basemul_montgomery), r0 then r1 per pair
// Define BASEMUL_REDUCE_EN to add a Barrett-reducing output stage (one extra cycle of latency).
module poly_basemul
    import ml_kem_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_valid,
    input  coeff_t i_a,
    input  coeff_t i_b,
    output logic   o_valid,
    output coeff_t o_data,
    output logic   o_last
);
    localparam int IW = $clog2(KYBER_N);
    localparam int PW = IW - 1;

    logic [IW-1:0] idx;
    logic [PW-1:0] s1_pair;
    logic [3:0] s1_v;
    logic launch, s1_valid, s2_valid, s2_last, hold_valid, hold_last, s3_valid, s3_last;
    coeff_t a0, b0, f00, f11, f01, f10, zeta_raw, zeta, fz, s2_a0b0, s2_r1, r1_hold, s3_data;

    assign launch = i_valid & idx[0];
    assign s1_valid = &s1_v;
    assign zeta_raw = coeff_t'(ZETAS[{1'b1, s1_pair[PW-1:1]}]);
    assign zeta = s1_pair[0] ? -zeta_raw : zeta_raw;

    // Index counter and even-beat capture; odd beats launch the pair straight into S1
    always_ff @(posedge i_clk) begin
        if (i_rst) idx <= '0;
        else if (i_valid) idx <= idx + IW'(1);
        if (i_valid && !idx[0]) begin
            a0 <= i_a;
            b0 <= i_b;
        end
        if (launch) s1_pair <= idx[IW-1:1];
    end

    fqmul u_f00 (.clk(i_clk), .rst(i_rst), .go(launch), .x(a0),  .y(b0),  .valid(s1_v[0]), .z(f00));
    fqmul u_f11 (.clk(i_clk), .rst(i_rst), .go(launch), .x(i_a), .y(i_b), .valid(s1_v[1]), .z(f11));
    fqmul u_f01 (.clk(i_clk), .rst(i_rst), .go(launch), .x(a0),  .y(i_b), .valid(s1_v[2]), .z(f01));
    fqmul u_f10 (.clk(i_clk), .rst(i_rst), .go(launch), .x(i_a), .y(b0),  .valid(s1_v[3]), .z(f10));
    fqmul u_fz  (.clk(i_clk), .rst(i_rst), .go(s1_valid), .x(f11), .y(zeta), .valid(s2_valid), .z(fz));

    // S2: carry a0*b0 alongside the zeta product, form r1 and flag the final pair
    always_ff @(posedge i_clk) begin
        if (s1_valid) begin
            s2_a0b0 <= f00;
            s2_r1 <= f01 + f10;
            s2_last <= &s1_pair;
        end
    end

    // S3: emit r0 from S2, park r1 in the hold register and emit it the following cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_last <= 1'b0;
            s3_data <= '0;
        end else begin
            hold_valid <= s2_valid;
            s3_valid <= s2_valid | hold_valid;
            s3_last <= hold_valid & hold_last;
            s3_data <= s2_valid ? fz + s2_a0b0 : hold_valid ? r1_hold : '0;
        end
        if (s2_valid) begin
            r1_hold <= s2_r1;
            hold_last <= s2_last;
        end
    end

`ifdef BASEMUL_REDUCE_EN
    // Output stage: Barrett-reduce every coefficient into the centred range
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_last <= 1'b0;
            o_data <= '0;
        end else begin
            o_valid <= s3_valid;
            o_last <= s3_last;
            o_data <= barrett_reduce(s3_data);
        end
    end
`else
    assign o_valid = s3_valid;
    assign o_last = s3_last;
    assign o_data = s3_data;
`endif
endmodule
